// File: rtl/chacha_block_engine.sv
// rtl/chacha_block_engine.sv - ChaCha keystream block generator with burst counter and valid/ready output
// Optional: define CHACHA_ZEROIZE_EN to wipe key-derived state at the end of each burst.
module chacha_block_engine #(
    parameter int ROUNDS       = 20,
    parameter int QR_PER_CYCLE = 4,
    parameter int BLK_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [255:0]         key,
    input  logic [95:0]          nonce,
    input  logic [31:0]          counter_init,
    input  logic [BLK_CNT_W-1:0] num_blocks,
    output logic [511:0]         ks_data,
    output logic                 ks_valid,
    input  logic                 ks_ready,
    output logic                 busy,
    output logic                 done,
    output logic [BLK_CNT_W-1:0] blocks_produced
);

    localparam int STEPS  = ROUNDS * 4 / QR_PER_CYCLE;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
        $error("chacha_block_engine: ROUNDS must be even and >= 2");
    end
    if (QR_PER_CYCLE != 1 && QR_PER_CYCLE != 4) begin : g_bad_qr
        $error("chacha_block_engine: QR_PER_CYCLE must be 1 or 4");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]           state;
    logic [511:0]         init_reg;
    logic [511:0]         work_reg;
    logic [STEP_W-1:0]    step_cnt;
    logic [BLK_CNT_W-1:0] nb_reg;

    logic [511:0]         init_state;
    logic [511:0]         init_next;
    logic [511:0]         step_next;
    logic [511:0]         ks_sum;
    logic [BLK_CNT_W-1:0] bp_inc;
    logic                 last_step;

    function automatic logic [511:0] apply_qr(input logic [511:0] s,
                                              input logic [3:0] ia, input logic [3:0] ib,
                                              input logic [3:0] ic, input logic [3:0] id);
        logic [31:0] a, b, c, d;
        logic [511:0] r;
        a = s[32*ia +: 32];
        b = s[32*ib +: 32];
        c = s[32*ic +: 32];
        d = s[32*id +: 32];
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        r = s;
        r[32*ia +: 32] = a;
        r[32*ib +: 32] = b;
        r[32*ic +: 32] = c;
        r[32*id +: 32] = d;
        return r;
    endfunction

    assign init_state = {nonce, counter_init, key,
                         32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    assign bp_inc     = blocks_produced + BLK_CNT_W'(1);
    assign last_step  = (step_cnt == STEP_W'(STEPS - 1));

    // Next block reuses key/nonce; only the counter word (12) advances, without carry into the nonce.
    always_comb begin
        init_next            = init_reg;
        init_next[415:384]   = init_reg[415:384] + 32'd1;
    end

    always_comb begin
        ks_sum = '0;
        for (int i = 0; i < 16; i++) begin
            ks_sum[32*i +: 32] = work_reg[32*i +: 32] + init_reg[32*i +: 32];
        end
    end

    if (QR_PER_CYCLE == 4) begin : g_qr4
        // Even steps are column rounds, odd steps diagonal rounds.
        always_comb begin
            step_next = work_reg;
            if (!step_cnt[0]) begin
                step_next = apply_qr(step_next, 4'd0, 4'd4, 4'd8,  4'd12);
                step_next = apply_qr(step_next, 4'd1, 4'd5, 4'd9,  4'd13);
                step_next = apply_qr(step_next, 4'd2, 4'd6, 4'd10, 4'd14);
                step_next = apply_qr(step_next, 4'd3, 4'd7, 4'd11, 4'd15);
            end else begin
                step_next = apply_qr(step_next, 4'd0, 4'd5, 4'd10, 4'd15);
                step_next = apply_qr(step_next, 4'd1, 4'd6, 4'd11, 4'd12);
                step_next = apply_qr(step_next, 4'd2, 4'd7, 4'd8,  4'd13);
                step_next = apply_qr(step_next, 4'd3, 4'd4, 4'd9,  4'd14);
            end
        end
    end else begin : g_qr1
        logic [1:0] j;
        logic [3:0] qa, qb, qc, qd;
        // Low three step bits walk the eight quarter-rounds of one double round.
        always_comb begin
            j  = step_cnt[1:0];
            qa = {2'b00, j};
            qb = {2'b01, j};
            qc = {2'b10, j};
            qd = {2'b11, j};
            if (step_cnt[2]) begin
                qb = {2'b01, j + 2'd1};
                qc = {2'b10, j + 2'd2};
                qd = {2'b11, j + 2'd3};
            end
            step_next = apply_qr(work_reg, qa, qb, qc, qd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            init_reg        <= '0;
            work_reg        <= '0;
            step_cnt        <= '0;
            nb_reg          <= '0;
            ks_data         <= '0;
            ks_valid        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            blocks_produced <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_blocks != '0) begin
                            init_reg        <= init_state;
                            work_reg        <= init_state;
                            step_cnt        <= '0;
                            nb_reg          <= num_blocks;
                            blocks_produced <= '0;
                            busy            <= 1'b1;
                            state           <= S_ROUND;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_ROUND: begin
                    work_reg <= step_next;
                    if (last_step) begin
                        step_cnt <= '0;
                        state    <= S_FINAL;
                    end else begin
                        step_cnt <= step_cnt + STEP_W'(1);
                    end
                end
                S_FINAL: begin
                    ks_data  <= ks_sum;
                    ks_valid <= 1'b1;
                    state    <= S_OUT;
                end
                default: begin
                    if (ks_valid && ks_ready) begin
                        ks_valid        <= 1'b0;
                        blocks_produced <= bp_inc;
                        if (bp_inc != nb_reg) begin
                            init_reg <= init_next;
                            work_reg <= init_next;
                            state    <= S_ROUND;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
`ifdef CHACHA_ZEROIZE_EN
                            ks_data  <= '0;
                            init_reg <= '0;
                            work_reg <= '0;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_block_engine.sv
// tb/tb_chacha_block_engine.sv - directed self-checking bench for chacha_block_engine (default and ChaCha8/QR1 builds)
module tb_chacha_block_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start8;
    logic [255:0] key_in;
    logic [95:0]  nonce_in;
    logic [31:0]  ctr_in;
    logic [15:0]  nb_in;
    logic         ks_ready, ks_ready8;

    logic [511:0] ks_data, ks_data8;
    logic         ks_valid, ks_valid8;
    logic         busy, busy8, done, done8;
    logic [15:0]  bp, bp8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chacha_block_engine dut (
        .clk(clk), .rst(rst), .start(start), .key(key_in), .nonce(nonce_in),
        .counter_init(ctr_in), .num_blocks(nb_in), .ks_data(ks_data), .ks_valid(ks_valid),
        .ks_ready(ks_ready), .busy(busy), .done(done), .blocks_produced(bp)
    );

    chacha_block_engine #(.ROUNDS(8), .QR_PER_CYCLE(1), .BLK_CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .key(key_in), .nonce(nonce_in),
        .counter_init(ctr_in), .num_blocks(nb_in), .ks_data(ks_data8), .ks_valid(ks_valid8),
        .ks_ready(ks_ready8), .busy(busy8), .done(done8), .blocks_produced(bp8)
    );

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c, input int rounds);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [511:0] r;
        int a, b, cc, d;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        for (int i = 0; i < 16; i++) x[i] = s[i];
        for (int rr = 0; rr < rounds / 2; rr++) begin
            for (int q = 0; q < 8; q++) begin
                case (q)
                    0: begin a = 0; b = 4; cc = 8;  d = 12; end
                    1: begin a = 1; b = 5; cc = 9;  d = 13; end
                    2: begin a = 2; b = 6; cc = 10; d = 14; end
                    3: begin a = 3; b = 7; cc = 11; d = 15; end
                    4: begin a = 0; b = 5; cc = 10; d = 15; end
                    5: begin a = 1; b = 6; cc = 11; d = 12; end
                    6: begin a = 2; b = 7; cc = 8;  d = 13; end
                    default: begin a = 3; b = 4; cc = 9; d = 14; end
                endcase
                x[a] = x[a] + x[b];  x[d] = rotl(x[d] ^ x[a], 16);
                x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
                x[a] = x[a] + x[b];  x[d] = rotl(x[d] ^ x[a], 8);
                x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    task automatic set_rfc();
        for (int i = 0; i < 32; i++) key_in[8*i +: 8] = 8'(i);
        nonce_in = {32'h00000000, 32'h4a000000, 32'h09000000};
        ctr_in   = 32'd1;
    endtask

    task automatic start_burst(input logic [15:0] nb);
        @(negedge clk);
        nb_in = nb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (ks_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ks_valid, busy, done, bp, ks_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%0b busy=%0b done=%0b bp=%0d", ks_valid, busy, done, bp);
        end
        checks++;
        if ({ks_valid8, busy8, done8, bp8, ks_data8} !== '0) begin
            errors++;
            $display("FAIL reset_outputs8 got valid=%0b busy=%0b done=%0b bp=%0d", ks_valid8, busy8, done8, bp8);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rfc_vector();
        int cyc;
        logic [511:0] exp;
        set_rfc();
        ks_ready = 1'b1;
        exp = ref_block(key_in, nonce_in, ctr_in, 20);
        start_burst(16'd1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rfc_busy got %0b want 1", busy); end
        wait_valid(cyc);
        checks++;
        if (cyc != 21) begin errors++; $display("FAIL rfc_latency got %0d want 21", cyc); end
        checks++;
        if (ks_data[31:0] !== 32'he4e7f110) begin errors++; $display("FAIL rfc_word0 got %h want e4e7f110", ks_data[31:0]); end
        checks++;
        if (ks_data[511:480] !== 32'h4e3c50a2) begin errors++; $display("FAIL rfc_word15 got %h want 4e3c50a2", ks_data[511:480]); end
        checks++;
        if (ks_data !== exp) begin errors++; $display("FAIL rfc_block got %h want %h", ks_data, exp); end
        @(negedge clk);
        checks++;
        if ({done, ks_valid, busy, bp} !== {1'b1, 1'b0, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL rfc_done got done=%0b valid=%0b busy=%0b bp=%0d want 1 0 0 1", done, ks_valid, busy, bp);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rfc_done_pulse got %0b want 0", done); end
    endtask

    task automatic test_counter_wrap();
        int cyc;
        logic [511:0] exp1, exp2;
        key_in   = {8{32'h13579bdf}} ^ {32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        nonce_in = {32'hcafef00d, 32'h01234567, 32'h89abcdef};
        ctr_in   = 32'hffffffff;
        ks_ready = 1'b1;
        exp1 = ref_block(key_in, nonce_in, 32'hffffffff, 20);
        exp2 = ref_block(key_in, nonce_in, 32'h00000000, 20);
        start_burst(16'd2);
        wait_valid(cyc);
        checks++;
        if (ks_data !== exp1) begin errors++; $display("FAIL wrap_block1 got %h want %h", ks_data, exp1); end
        @(negedge clk);
        wait_valid(cyc);
        checks++;
        if (cyc != 21) begin errors++; $display("FAIL wrap_latency2 got %0d want 21", cyc); end
        checks++;
        if (ks_data !== exp2) begin errors++; $display("FAIL wrap_block2 got %h want %h", ks_data, exp2); end
        checks++;
        if (bp !== 16'd1) begin errors++; $display("FAIL wrap_bp_mid got %0d want 1", bp); end
        @(negedge clk);
        checks++;
        if ({bp, done, busy} !== {16'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_end got bp=%0d done=%0b busy=%0b want 2 1 0", bp, done, busy);
        end
    endtask

    task automatic test_backpressure();
        int cyc, unstable;
        logic [511:0] held;
        set_rfc();
        ctr_in   = 32'd7;
        ks_ready = 1'b0;
        start_burst(16'd1);
        wait_valid(cyc);
        held = ks_data;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ks_valid !== 1'b1 || ks_data !== held || bp !== 16'd0) unstable++;
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", unstable); end
        checks++;
        if (held !== ref_block(key_in, nonce_in, 32'd7, 20)) begin errors++; $display("FAIL bp_block got %h", held); end
        ks_ready = 1'b1;
        @(negedge clk);
        ks_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bp, ks_valid, busy} !== {16'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL bp_handshake got bp=%0d valid=%0b busy=%0b want 1 0 0", bp, ks_valid, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        set_rfc();
        ks_ready = 1'b1;
        start_burst(16'd4);
        wait_valid(cyc);
        @(negedge clk);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ks_valid, busy, done, bp, ks_data} !== '0) begin
            errors++;
            $display("FAIL midrst_async got valid=%0b busy=%0b bp=%0d data=%h", ks_valid, busy, bp, ks_data);
        end
        @(negedge clk);
        rst = 1'b0;
        start_burst(16'd1);
        wait_valid(cyc);
        checks++;
        if (cyc != 21) begin errors++; $display("FAIL midrst_latency got %0d want 21", cyc); end
        checks++;
        if (ks_data !== ref_block(key_in, nonce_in, 32'd1, 20)) begin errors++; $display("FAIL midrst_block got %h", ks_data); end
        @(negedge clk);
    endtask

    task automatic test_zero_blocks();
        int bad;
        start_burst(16'd0);
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("FAIL zero_done got done=%0b busy=%0b want 1 0", done, busy); end
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (ks_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL zero_quiet got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        logic [511:0] exp;
        set_rfc();
        ctr_in   = 32'd42;
        ks_ready = 1'b1;
        exp = ref_block(key_in, nonce_in, 32'd42, 20);
        start_burst(16'd1);
        repeat (5) @(negedge clk);
        key_in = ~key_in;
        ctr_in = 32'd99;
        nb_in  = 16'd3;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_valid(cyc);
        checks++;
        if (ks_data !== exp) begin errors++; $display("FAIL busy_start_block got %h want %h", ks_data, exp); end
        @(negedge clk);
        checks++;
        if ({done, busy, bp} !== {1'b1, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL busy_start_end got done=%0b busy=%0b bp=%0d want 1 0 1", done, busy, bp);
        end
    endtask

    task automatic test_chacha8_qr1();
        int cyc;
        logic [511:0] exp;
        set_rfc();
        ks_ready8 = 1'b1;
        exp = ref_block(key_in, nonce_in, 32'd1, 8);
        @(negedge clk);
        nb_in  = 16'd1;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (ks_valid8 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 33) begin errors++; $display("FAIL c8_latency got %0d want 33", cyc); end
        checks++;
        if (ks_data8 !== exp) begin errors++; $display("FAIL c8_block got %h want %h", ks_data8, exp); end
        @(negedge clk);
        checks++;
        if ({done8, busy8, bp8} !== {1'b1, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL c8_done got done=%0b busy=%0b bp=%0d want 1 0 1", done8, busy8, bp8);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        start8    = 1'b0;
        key_in    = '0;
        nonce_in  = '0;
        ctr_in    = '0;
        nb_in     = '0;
        ks_ready  = 1'b0;
        ks_ready8 = 1'b0;
        test_reset();
        test_rfc_vector();
        test_counter_wrap();
        test_backpressure();
        test_reset_mid_burst();
        test_zero_blocks();
        test_start_while_busy();
        test_chacha8_qr1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
